spi_tx: RTL and testbench
=========================

# spi_tx

Serializer counterpart of the team's `spi_rx` deserializer. It accepts parallel bytes through a valid/ready handshake and shifts them out one bit per rising `clk` edge, least-significant bit first, so that `spi_rx` reconstructs each byte unchanged. A one-entry holding register allows gapless back-to-back bytes. A synchronous `flush` aborts the byte in flight and discards any queued byte.

## Interface
- `DATA_W`, default 8: bits per frame; must be ≥ 2.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `byte_in`  input  DATA_W  parallel data to send.
- `load`  input  1  `byte_in` valid; transfer occurs on an edge where `load && ready`.
- `flush`  input  1  active-high synchronous abort.
- `ready`  output  1  holding register empty; can accept a byte.
- `bit_out`  output  1  serial data; LSB of the frame first.
- `bit_valid`  output  1  `bit_out` carries a frame bit this cycle.
- `last`  output  1  `bit_out` is bit DATA_W-1 of the current frame.
- `busy`  output  1  frame in flight or byte queued (`bit_valid | ~ready`).

## Operation
- State `IDLE`: no frame in flight.
- State `SHIFT`: frame in flight.
- Internal registers:
  - `shift_reg[DATA_W]`
  - `cnt` (clog2(DATA_W) bits, 0..DATA_W-1)
  - `hold_reg[DATA_W]`
  - `hold_full`
- `ready = ~hold_full`. It depends only on registered state, never combinationally on `load`.
- Accept in `IDLE` (hold empty): `byte_in` goes to `shift_reg`, `cnt = 0`, state becomes `SHIFT`.
- Accept in `SHIFT` when `cnt != DATA_W-1`: `byte_in` goes to `hold_reg`, `hold_full = 1`.
- Each `SHIFT` edge with `cnt != DATA_W-1`: `shift_reg >>= 1`, `cnt++`.
- End-of-frame edge (`SHIFT`, `cnt == DATA_W-1`), in priority order:
  1. If `hold_full`: `hold_reg` goes to `shift_reg`, `cnt = 0`, `hold_full = 0`, stay in `SHIFT`.
  2. Else if `load` (ready is 1): `byte_in` goes to `shift_reg`, `cnt = 0`, stay in `SHIFT`.
  3. Else: go to `IDLE`.
  - Cases 1 and 2 produce no idle cycle between frames.
- When case 1 fires and `load` is also high, `ready` was 0, so `load` is not accepted.
- Outputs:
  - `bit_out = shift_reg[0]` in `SHIFT`, 0 in `IDLE`.
  - `bit_valid = (state == SHIFT)`.
  - `last = bit_valid && cnt == DATA_W-1`.
- `flush` (highest priority below reset): clears `shift_reg`, `hold_reg`, `hold_full` and `cnt`, and forces `IDLE`. A `load` on the same edge is not accepted.
- Holding `flush` high keeps the block in `IDLE` with `ready = 1`.

## Timing
- Reset values:
  - `ready = 1`
  - `bit_out = 0`, `bit_valid = 0`, `last = 0`, `busy = 0`
  - internal registers 0, state `IDLE`
- Reset asserted mid-frame aborts immediately and asynchronously; no partial bits follow.
- Latency: a byte accepted at edge t0 from `IDLE` drives bit 0 during cycle t0..t1, bit k during cycle t0+k. `last` is high in cycle t0+DATA_W-1.
- Throughput: one bit per clock; a frame every DATA_W clocks when fed continuously.
- At most 2 bytes are ever outstanding: 1 shifting + 1 held.
- `ready` falls the cycle after a byte is accepted into hold. It rises the cycle after the end-of-frame edge that moves hold into the shifter.
- `flush` at edge t: `bit_valid = 0` from cycle t onward; `ready = 1` from t.

## Structure
- Package `spi_pkg`:
  - `localparam SPI_DATA_W = 8` (the default for `DATA_W`)
  - state enum `spi_tx_state_t {IDLE, SHIFT}`
  - bit-count width function
- Sub-module `spi_tx_hold`: the one-entry holding register with `push`, `pop`, `clear`, `full` and `data`.
- The shifter, counter and FSM stay in `spi_tx`.

## Test plan
- Reset then single byte: load 0xCA → `bit_out` 0,1,0,1,0,0,1,1 over 8 cycles; `last` only on the 8th; then `bit_valid = 0` and `ready = 1`.
- Back-to-back: load 0x53 then 0x3F while busy → 16 contiguous valid bits 1,1,0,0,1,0,1,0,1,1,1,1,1,1,0,0. `ready` is 0 from the cycle after 0x3F is accepted until the end-of-frame edge.
- Load on the last-bit edge with hold empty → next frame starts with no gap; `bit_valid` stays 1.
- Flush mid-frame after 3 bits of 0xFF with 0x0F held → `bit_valid = 0` the cycle after the flush edge and 0x0F is discarded. A following load of 0xA5 yields 1,0,1,0,0,1,0,1.
- Async reset mid-frame → all outputs 0 without waiting for a clock edge; recovery sends a subsequent 0x81 correctly.
- Loopback into `spi_rx` (same `clk`, flush released together) with a gapless stream 0x53, 0xFC, 0xE5 → `spi_rx.byte` shows 0x53, then 0xFC, then 0xE5, each updated 8 clocks apart.

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants, state encoding and helpers for the SPI serializer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_tx_state_t;

  // Width of a counter spanning 0..data_w-1, never narrower than one bit.
  function automatic int spi_cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_hold.sv
// ============================================================================
// Module   : spi_tx_hold
// Brief    : One-entry holding register queueing the next byte to serialize.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_tx_hold
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/spi_tx.sv
// ============================================================================
// Module   : spi_tx
// Brief    : LSB-first serializer with valid/ready byte input and one-byte queue.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              load,
  input  logic              flush,
  output logic              ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              last,
  output logic              busy
);

  localparam int                 c_cnt_w    = spi_cnt_w(DATA_W);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(DATA_W - 1);

  spi_tx_state_t      state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  logic              w_hold_full;
  logic              w_hold_push;
  logic              w_hold_pop;
  logic [DATA_W-1:0] w_hold_data;
  logic              w_accept;

  // ready is purely registered, so acceptance never loops back through load.
  assign ready    = ~w_hold_full;
  assign w_accept = load & ready & ~flush;

  spi_tx_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_hold_push),
    .pop_i   (w_hold_pop),
    .clear_i (flush),
    .data_i  (byte_in),
    .full_o  (w_hold_full),
    .data_o  (w_hold_data)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    w_hold_push = 1'b0;
    w_hold_pop  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_accept) begin
            shift_d = byte_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != c_last_cnt) begin
            shift_d     = shift_q >> 1;
            cnt_d       = cnt_q + 1'b1;
            w_hold_push = w_accept;
          end else if (w_hold_full) begin
            shift_d    = w_hold_data;
            cnt_d      = '0;
            w_hold_pop = 1'b1;
          end else if (w_accept) begin
            shift_d = byte_in;
            cnt_d   = '0;
          end else begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_valid = (state_q == SHIFT);
  assign bit_out   = bit_valid & shift_q[0];
  assign last      = bit_valid & (cnt_q == c_last_cnt);
  assign busy      = bit_valid | ~ready;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx.sv
// ============================================================================
// Module   : tb_spi_tx
// Brief    : Directed self-checking bench for spi_tx with an LSB-first receiver model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_tx;

  localparam int DATA_W = 8;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              load    = 1'b0;
  logic              flush   = 1'b0;
  logic [DATA_W-1:0] byte_in = '0;
  logic              ready, bit_out, bit_valid, last, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  spi_tx #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .load      (load),
    .flush     (flush),
    .ready     (ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .last      (last),
    .busy      (busy)
  );

  // Receiver model: collects valid bits LSB first into bytes.
  logic [7:0] rx_sr  = '0;
  int         rx_cnt = 0;
  logic [7:0] rx_hist[$];
  int         rx_stamp[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr  <= '0;
      rx_cnt <= 0;
    end else if (flush) begin
      rx_cnt <= 0;
    end else if (bit_valid) begin
      rx_sr <= {bit_out, rx_sr[7:1]};
      if (rx_cnt == 7) begin
        rx_hist.push_back({bit_out, rx_sr[7:1]});
        rx_stamp.push_back(cyc);
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n consecutive frame-bit cycles; optionally presents a load at cycle ld_at.
  task automatic play(input string tag, input logic [15:0] bits, input int n,
                      input logic [15:0] last_m, input logic [15:0] rdy_m,
                      input int ld_at, input logic [7:0] ld_byte);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]_valid", tag, i), 32'(bit_valid), 32'd1);
      chk($sformatf("%s[%0d]_bit", tag, i), 32'(bit_out), 32'(bits[i]));
      chk($sformatf("%s[%0d]_last", tag, i), 32'(last), 32'(last_m[i]));
      chk($sformatf("%s[%0d]_ready", tag, i), 32'(ready), 32'(rdy_m[i]));
      chk($sformatf("%s[%0d]_busy", tag, i), 32'(busy), 32'd1);
      if (i == ld_at) begin
        load    = 1'b1;
        byte_in = ld_byte;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_bit"}, 32'(bit_out), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic start(input logic [7:0] b);
    load    = 1'b1;
    byte_in = b;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] feed [3];
    int         base;
    int         idx;
    feed[0] = 8'h53;
    feed[1] = 8'hFC;
    feed[2] = 8'hE5;

    tick();
    tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Single byte 0xCA: 0,1,0,1,0,0,1,1
    start(8'hCA);
    play("single", 16'b00000000_11001010, 8, 16'h0080, 16'hFFFF, -1, 8'h00);
    chk_idle("single_end");

    // Back-to-back 0x53 then 0x3F queued during the first frame
    start(8'h53);
    play("b2b", 16'b00111111_01010011, 16, 16'h8080, 16'hFF01, 0, 8'h3F);
    chk_idle("b2b_end");

    // Load on the last-bit edge with hold empty: 0xCA then 0x81 gapless
    start(8'hCA);
    play("lastload", 16'b10000001_11001010, 16, 16'h8080, 16'hFFFF, 7, 8'h81);
    chk_idle("lastload_end");

    // Flush after 3 bits of 0xFF with 0x0F held
    start(8'hFF);
    load    = 1'b1;
    byte_in = 8'h0F;
    tick();
    load = 1'b0;
    tick();
    chk("flush_pre_ready", 32'(ready), 32'd0);
    chk("flush_pre_valid", 32'(bit_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_idle("flush");
    tick();
    tick();
    tick();
    chk("flush_discard_valid", 32'(bit_valid), 32'd0);

    // Flush and load on the same edge: load must be ignored
    flush   = 1'b1;
    load    = 1'b1;
    byte_in = 8'h33;
    tick();
    tick();
    flush = 1'b0;
    load  = 1'b0;
    chk_idle("flush_load");
    tick();
    chk("flush_load_after", 32'(bit_valid), 32'd0);

    start(8'hA5);
    play("after_flush", 16'b00000000_10100101, 8, 16'h0080, 16'hFFFF, -1, 8'h00);
    chk_idle("after_flush_end");

    // Asynchronous reset mid-frame, then recovery with 0x81
    start(8'hFF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("async_rst_rel");
    start(8'h81);
    play("recover", 16'b00000000_10000001, 8, 16'h0080, 16'hFFFF, -1, 8'h00);
    chk_idle("recover_end");

    // Loopback: gapless 0x53, 0xFC, 0xE5 into the receiver model
    base = rx_hist.size();
    idx  = 0;
    for (int k = 0; k < 60 && rx_hist.size() < base + 3; k++) begin
      if (idx < 3 && ready) begin
        load    = 1'b1;
        byte_in = feed[idx];
        idx++;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    chk("loop_count", 32'(rx_hist.size() - base), 32'd3);
    if (rx_hist.size() >= base + 3) begin
      chk("loop_b0", 32'(rx_hist[base]), 32'h53);
      chk("loop_b1", 32'(rx_hist[base + 1]), 32'hFC);
      chk("loop_b2", 32'(rx_hist[base + 2]), 32'hE5);
      chk("loop_gap01", 32'(rx_stamp[base + 1] - rx_stamp[base]), 32'd8);
      chk("loop_gap12", 32'(rx_stamp[base + 2] - rx_stamp[base + 1]), 32'd8);
    end
    tick();
    chk_idle("loop_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
